// File: rtl/uart_tx.sv
// UART transmitter: start bit, 7/8 data bits LSB first, optional even parity, one stop bit.
// Frame settings are latched when a write is accepted; the serial line idles high.
module uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD_LOW    = 9600,
  parameter int unsigned BAUD_HIGH   = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_ParityEn,
  input  logic       i_Datalength,
  input  logic       i_Baudrate,
  input  logic [7:0] i_Data,
  input  logic       i_WriteEnable,
  output logic       o_DataOut,
  output logic       o_Busy
);

  localparam int unsigned DivLowInt  = CLK_FREQ_HZ / BAUD_LOW;
  localparam int unsigned DivHighInt = CLK_FREQ_HZ / BAUD_HIGH;
  localparam logic [12:0] DivLow     = 13'(DivLowInt);
  localparam logic [12:0] DivHigh    = 13'(DivHighInt);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  data_q;
  logic        parity_q, par_en_q, len8_q, baud_q;
  logic        we_q, we_prev_q;
  logic        dout_q, dout_d;
  logic        busy_q, busy_d;

  logic [12:0] div;
  logic        bit_done;
  logic        start;
  logic        load;
  logic [2:0]  last_idx;
  logic [7:0]  data_masked;

  assign div         = baud_q ? DivHigh : DivLow;
  assign bit_done    = (cnt_q == div - 13'd1);
  assign last_idx    = len8_q ? 3'd7 : 3'd6;
  // Only a 0->1 transition of the registered strobe starts a frame, and only from idle.
  assign start       = (state_q == StIdle) && we_q && !we_prev_q;
  // Bit 7 is forced low in 7-bit mode so it cannot leak into the parity.
  assign data_masked = i_Datalength ? i_Data : {1'b0, i_Data[6:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load    = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_done ? 13'd0 : cnt_q + 13'd1;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = 13'd0;
        idx_d = 3'd0;
        if (start) begin
          state_d = StStart;
          load    = 1'b1;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          idx_d   = 3'd0;
        end
      end
      StData: begin
        if (bit_done) begin
          if (idx_q == last_idx) begin
            state_d = par_en_q ? StParity : StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_done) state_d = StStop;
      end
      StStop: begin
        if (bit_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    dout_d = 1'b1;
    unique case (state_d)
      StIdle:   dout_d = 1'b1;
      StStart:  dout_d = 1'b0;
      StData:   dout_d = data_q[idx_d];
      StParity: dout_d = parity_q;
      StStop:   dout_d = 1'b1;
      default:  dout_d = 1'b1;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 13'd0;
      idx_q     <= 3'd0;
      data_q    <= 8'd0;
      parity_q  <= 1'b0;
      par_en_q  <= 1'b0;
      len8_q    <= 1'b0;
      baud_q    <= 1'b0;
      we_q      <= 1'b0;
      we_prev_q <= 1'b0;
      dout_q    <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      we_q      <= i_WriteEnable;
      we_prev_q <= we_q;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      if (load) begin
        data_q   <= data_masked;
        parity_q <= ^data_masked;
        par_en_q <= i_ParityEn;
        len8_q   <= i_Datalength;
        baud_q   <= i_Baudrate;
      end
    end
  end

  assign o_DataOut = dout_q;
  assign o_Busy    = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame bit patterns, bit timing, busy length, edge handling, reset.
// BAUD_HIGH is raised to 1 Mbaud (50 clocks/bit) to keep the byte sweep short.
module tb_uart_tx;

  localparam int DivLo = 5208;
  localparam int DivHi = 50;

  logic       clock = 1'b0;
  logic       reset;
  logic       parity_en;
  logic       datalen;
  logic       baud;
  logic [7:0] data;
  logic       we;
  logic       dout;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx #(
    .CLK_FREQ_HZ(50_000_000),
    .BAUD_LOW   (9600),
    .BAUD_HIGH  (1_000_000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .i_ParityEn   (parity_en),
    .i_Datalength (datalen),
    .i_Baudrate   (baud),
    .i_Data       (data),
    .i_WriteEnable(we),
    .o_DataOut    (dout),
    .o_Busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected frame, first transmitted bit in bit 0.
  task automatic model(input logic [7:0] d, input bit len8, input bit par,
                       output logic [10:0] bits, output int nb);
    int  n;
    int  k;
    logic p;
    bits = '0;
    p    = 1'b0;
    n    = len8 ? 8 : 7;
    k    = 1;
    for (int i = 0; i < n; i++) begin
      bits[k] = d[i];
      p       = p ^ d[i];
      k++;
    end
    if (par) begin
      bits[k] = p;
      k++;
    end
    bits[k] = 1'b1;
    nb      = k + 1;
  endtask

  // Call right after driving a 0->1 strobe at a negedge.
  task automatic run_frame(input string tag, input logic [10:0] exp_bits, input int nbits,
                           input int div, input int hold, input bit disturb,
                           output logic [10:0] mid);
    int cnt;
    int j;
    int err [11];
    for (int i = 0; i < 11; i++) err[i] = 0;
    mid = '0;
    @(negedge clock);
    check({tag, " busy before k+1"}, busy, 1'b0);
    @(negedge clock);
    check({tag, " busy at k+1"}, busy, 1'b1);
    cnt = 0;
    while (busy === 1'b1 && cnt < nbits * div + 5) begin
      j = cnt / div;
      if (j < nbits) begin
        if (dout !== exp_bits[j]) err[j]++;
        if (cnt == j * div + div / 2) mid[j] = dout;
      end
      if (cnt == hold) we = 1'b0;
      if (disturb && cnt == 3 * div + 7) begin
        data      = ~data;
        parity_en = ~parity_en;
        datalen   = ~datalen;
        we        = 1'b1;
      end
      if (disturb && cnt == 3 * div + 20) we = 1'b0;
      cnt++;
      @(negedge clock);
    end
    check({tag, " busy length"}, cnt, nbits * div);
    for (int b = 0; b < nbits; b++) begin
      check($sformatf("%s bit%0d", tag, b), mid[b], exp_bits[b]);
      check($sformatf("%s bit%0d wrong cycles", tag, b), err[b], 0);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    int bad = 0;
    repeat (n) begin
      @(negedge clock);
      if (busy !== 1'b0 || dout !== 1'b1) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    logic [10:0] mid;
    logic [10:0] bits;
    int          nb;

    reset     = 1'b0;
    we        = 1'b0;
    parity_en = 1'b0;
    datalen   = 1'b0;
    baud      = 1'b0;
    data      = 8'h00;

    // Reset and idle line
    repeat (5) @(negedge clock);
    check("reset dout", dout, 1'b1);
    check("reset busy", busy, 1'b0);
    reset = 1'b1;
    idle_check("idle after reset", 10000);

    // 9600 baud, 7 bits, even parity, 0x50: 0,0000101,0,1
    @(negedge clock);
    baud = 1'b0; datalen = 1'b0; parity_en = 1'b1; data = 8'h50; we = 1'b1;
    run_frame("f50_9600", 11'h2A0, 10, DivLo, 8, 1'b0, mid);
    idle_check("f50_9600 single frame", 200);

    // High baud, 8 bits, no parity, 0xA5: 0,10100101,1
    @(negedge clock);
    baud = 1'b1; datalen = 1'b1; parity_en = 1'b0; data = 8'hA5; we = 1'b1;
    run_frame("fA5", 11'h34A, 10, DivHi, 8, 1'b0, mid);
    idle_check("fA5 single frame", 200);

    // Sweep 0x50..0x63, 7 bits with parity, decoded like a receiver
    for (int d = 8'h50; d <= 8'h63; d++) begin
      logic [7:0] dv;
      dv = 8'(d);
      model(dv, 1'b0, 1'b1, bits, nb);
      @(negedge clock);
      baud = 1'b1; datalen = 1'b0; parity_en = 1'b1; data = dv; we = 1'b1;
      run_frame($sformatf("sweep%02h", dv), bits, nb, DivHi, 2, 1'b0, mid);
      check($sformatf("sweep%02h rx data", dv), {1'b0, mid[7:1]}, {1'b0, dv[6:0]});
      check($sformatf("sweep%02h rx parity err", dv), ^mid[8:1], 1'b0);
    end

    // New edge plus input changes mid-frame: frame unchanged, nothing queued
    @(negedge clock);
    baud = 1'b1; datalen = 1'b1; parity_en = 1'b0; data = 8'hA5; we = 1'b1;
    run_frame("midwr", 11'h34A, 10, DivHi, 8, 1'b1, mid);
    idle_check("midwr no second frame", 300);

    // Reset during DATA, then a clean frame
    @(negedge clock);
    baud = 1'b1; datalen = 1'b1; parity_en = 1'b0; data = 8'h3C; we = 1'b1;
    repeat (2 + 3 * DivHi) @(negedge clock);
    we = 1'b0;
    check("pre-reset busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid reset dout", dout, 1'b1);
    check("mid reset busy", busy, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    idle_check("after mid reset idle", 20);
    @(negedge clock);
    data = 8'hA5; we = 1'b1;
    run_frame("post_reset", 11'h34A, 10, DivHi, 8, 1'b0, mid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
